frac_symbol_clk_gen: RTL

Parametrised fractional-N symbol clock generator for the CDR block. It produces a one-cycle symbol pulse, a stretched strobe and an NCO-derived ADC clock from a single `clk_4x` domain. Divider width, fraction width, strobe length and NCO width are configurable. A handshaked config port applies a new ratio glitch-free at the next symbol boundary. An optional early/late phase-nudge port lets the CDR loop slip one cycle per symbol.

---
 rtl/frac_symbol_clk_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/frac_symbol_clk_gen.sv
// Fractional-N symbol clock generator: symbol pulse, stretched strobe and NCO-derived ADC clock, all on clk_4x.
// Define CDR_PHASE_ADJ_EN to enable the early/late one-cycle phase nudge from the CDR loop.
module frac_symbol_clk_gen #(
    parameter int unsigned INT_W    = 10,
    parameter int unsigned FRAC_W   = 22,
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned STRETCH  = 3,
    parameter bit          ADC_SYNC = 1'b1
) (
    input  logic              clk_4x,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [INT_W-1:0]  i_cfg_div,
    input  logic [FRAC_W-1:0] i_cfg_frac,
    input  logic [ACC_W-1:0]  i_cfg_adc_step,
    input  logic              i_adj_early,
    input  logic              i_adj_late,
    output logic              o_sym_pulse,
    output logic              o_sym_strobe,
    output logic              o_adc_clk
);
    localparam int unsigned LEN_W = INT_W + 1;
    localparam int unsigned STR_W = (STRETCH > 1) ? $clog2(STRETCH) : 1;

    logic [INT_W-1:0]  r_div_q;
    logic [FRAC_W-1:0] r_frac_q;
    logic [ACC_W-1:0]  r_step_q;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic [FRAC_W-1:0] r_facc;
    logic [ACC_W-1:0]  r_aacc;
    logic [STR_W-1:0]  r_scnt;
    logic              r_pend_v;
    logic [INT_W-1:0]  r_pend_div;
    logic [FRAC_W-1:0] r_pend_frac;
    logic [ACC_W-1:0]  r_pend_step;
    logic              r_cfg_ready;
    logic              r_sym_pulse;
    logic              r_sym_strobe;

    logic              w_cfg_fire;
    logic              w_wrap;
    logic              w_carry;
    logic              w_adj_inc;
    logic              w_adj_dec;
    logic [INT_W-1:0]  w_cfg_div_cl;
    logic [FRAC_W:0]   w_frac_sum;
    logic [LEN_W-1:0]  w_len_sum;
    logic [LEN_W-1:0]  w_len_next;

    assign w_cfg_fire   = i_cfg_valid & r_cfg_ready;
    assign w_cfg_div_cl = (i_cfg_div < INT_W'(2)) ? INT_W'(2) : i_cfg_div;
    assign w_wrap       = (r_cnt == (r_len - LEN_W'(1)));
    assign w_frac_sum   = {1'b0, r_facc} + {1'b0, r_frac_q};
    assign w_carry      = w_frac_sum[FRAC_W];
    // adj is -1/0/+1; div_q >= 2 so the subtraction cannot underflow
    assign w_len_sum    = {1'b0, r_div_q} + LEN_W'(w_carry) + LEN_W'(w_adj_inc) - LEN_W'(w_adj_dec);
    assign w_len_next   = (w_len_sum < LEN_W'(2)) ? LEN_W'(2) : w_len_sum;

    // Period counter, fractional accumulator, config shadowing, stretch and ADC NCO
    always_ff @(posedge clk_4x) begin
        if (reset) begin
            r_div_q      <= INT_W'(2);
            r_frac_q     <= '0;
            r_step_q     <= '0;
            r_cnt        <= '0;
            r_len        <= LEN_W'(2);
            r_facc       <= '0;
            r_aacc       <= '0;
            r_scnt       <= '0;
            r_pend_v     <= 1'b0;
            r_pend_div   <= '0;
            r_pend_frac  <= '0;
            r_pend_step  <= '0;
            r_cfg_ready  <= 1'b1;
            r_sym_pulse  <= 1'b0;
            r_sym_strobe <= 1'b0;
        end else if (!i_en) begin
            r_cnt        <= '0;
            r_facc       <= '0;
            r_aacc       <= '0;
            r_scnt       <= '0;
            r_sym_pulse  <= 1'b0;
            r_sym_strobe <= 1'b0;
            r_cfg_ready  <= ~r_pend_v;
            if (w_cfg_fire) begin
                r_div_q  <= w_cfg_div_cl;
                r_frac_q <= i_cfg_frac;
                r_step_q <= i_cfg_adc_step;
                r_len    <= LEN_W'(w_cfg_div_cl);
            end else begin
                r_len    <= LEN_W'(r_div_q);
            end
        end else begin
            r_sym_pulse <= w_wrap;
            r_aacc      <= (w_wrap && ADC_SYNC) ? '0 : r_aacc + r_step_q;
            r_cfg_ready <= ~(r_pend_v | w_cfg_fire);
            if (w_wrap) begin
                r_cnt        <= '0;
                r_sym_strobe <= 1'b1;
                r_scnt       <= STR_W'(STRETCH - 1);
                if (r_pend_v) begin
                    r_div_q  <= r_pend_div;
                    r_frac_q <= r_pend_frac;
                    r_step_q <= r_pend_step;
                    r_facc   <= '0;
                    r_len    <= LEN_W'(r_pend_div);
                    r_pend_v <= 1'b0;
                end else begin
                    r_facc   <= w_frac_sum[FRAC_W-1:0];
                    r_len    <= w_len_next;
                end
            end else begin
                r_cnt <= r_cnt + LEN_W'(1);
                if (r_scnt != '0) begin
                    r_scnt <= r_scnt - STR_W'(1);
                end else begin
                    r_sym_strobe <= 1'b0;
                end
            end
            if (w_cfg_fire) begin
                r_pend_v    <= 1'b1;
                r_pend_div  <= w_cfg_div_cl;
                r_pend_frac <= i_cfg_frac;
                r_pend_step <= i_cfg_adc_step;
            end
        end
    end

`ifdef CDR_PHASE_ADJ_EN
    logic r_adj_inc;
    logic r_adj_dec;
    logic w_early;
    logic w_late;

    assign w_early = i_adj_early & ~i_adj_late;
    assign w_late  = i_adj_late & ~i_adj_early;

    // First strobe in a period wins; a strobe on the pulse edge lands in the following period
    always_ff @(posedge clk_4x) begin
        if (reset) begin
            r_adj_inc <= 1'b0;
            r_adj_dec <= 1'b0;
        end else if (i_en) begin
            if (w_wrap || (!r_adj_inc && !r_adj_dec)) begin
                r_adj_inc <= w_late;
                r_adj_dec <= w_early;
            end
        end
    end

    assign w_adj_inc = r_adj_inc;
    assign w_adj_dec = r_adj_dec;
`else
    logic w_unused_adj;
    assign w_unused_adj = i_adj_early ^ i_adj_late;
    assign w_adj_inc    = 1'b0;
    assign w_adj_dec    = 1'b0;
`endif

    assign o_cfg_ready  = r_cfg_ready;
    assign o_sym_pulse  = r_sym_pulse;
    assign o_sym_strobe = r_sym_strobe;
    assign o_adc_clk    = r_aacc[ACC_W-1];

endmodule
